// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Issues sequential word fetches to a variable-latency instruction memory
// (valid/ready request, in-order unthrottled response), tags each live
// request with its PC and buffers returned instructions in a prefetch FIFO.
// A redirect flushes the FIFO and turns every in-flight request into a
// discard credit, so stale responses are dropped without being written.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   imem_req_valid/ready   fetch request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/data    in-order instruction response
//   redirect_valid/pc      restart fetch at a new PC, flushing everything
//   out_valid/ready        consumer handshake on the FIFO head
//   out_instr/pc/pc_plus_four  head instruction, its PC and PC+4
module fetch_unit #(
    parameter int                 XLEN            = 32,
    parameter logic [XLEN-1:0]    RESET_PC        = '0,
    parameter int                 FIFO_DEPTH      = 4,
    parameter int                 MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_four
);

    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TI_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SUM_W = ((FC_W > OC_W) ? FC_W : OC_W) + 1;

    // Tag queue depth need not be a power of two, so wrap explicitly.
    function automatic logic [TI_W-1:0] tag_inc(input logic [TI_W-1:0] p);
        return (p == TI_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [FA_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [FA_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [FC_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
    logic [TI_W-1:0] tag_wr_q, tag_wr_d;
    logic [TI_W-1:0] tag_rd_q, tag_rd_d;

    // live: requests whose response will be kept; discard: responses owed
    // to requests issued before the last redirect.
    logic [OC_W-1:0] live_cnt_q, live_cnt_d;
    logic [OC_W-1:0] discard_cnt_q, discard_cnt_d;

    logic [SUM_W-1:0] inflight;
    logic             credit_ok, space_ok;
    logic             acc, rsp_ok, rsp_keep, rsp_disc, pop;

    // Request gating uses registered state only.
    assign inflight  = SUM_W'(live_cnt_q) + SUM_W'(discard_cnt_q);
    assign credit_ok = inflight < SUM_W'(MAX_OUTSTANDING);
    assign space_ok  = (SUM_W'(fifo_cnt_q) + SUM_W'(live_cnt_q)) < SUM_W'(FIFO_DEPTH);

    assign imem_req_valid = rst_n && credit_ok && space_ok;
    assign imem_req_addr  = fetch_pc_q;

    assign acc      = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error: ignore it.
    assign rsp_ok   = imem_rsp_valid && (inflight != '0);
    assign rsp_disc = rsp_ok && (discard_cnt_q != '0);
    assign rsp_keep = rsp_ok && (discard_cnt_q == '0) && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        live_cnt_d    = live_cnt_q;
        discard_cnt_d = discard_cnt_q;

        if (acc)
            fetch_pc_d = fetch_pc_q + XLEN'(4);

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc;
            fifo_wr_d     = '0;
            fifo_rd_d     = '0;
            fifo_cnt_d    = '0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            live_cnt_d    = '0;
            // Every outstanding request, including one accepted now, becomes
            // a discard; a response arriving now retires one of them.
            discard_cnt_d = discard_cnt_q + live_cnt_q + OC_W'(acc) - OC_W'(rsp_ok);
        end else begin
            if (acc)
                tag_wr_d = tag_inc(tag_wr_q);
            if (rsp_keep) begin
                tag_rd_d  = tag_inc(tag_rd_q);
                fifo_wr_d = fifo_wr_q + 1'b1;
            end
            if (pop)
                fifo_rd_d = fifo_rd_q + 1'b1;
            live_cnt_d    = live_cnt_q + OC_W'(acc) - OC_W'(rsp_keep);
            discard_cnt_d = discard_cnt_q - OC_W'(rsp_disc);
            fifo_cnt_d    = fifo_cnt_q + FC_W'(rsp_keep) - FC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            live_cnt_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            live_cnt_q    <= live_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (rst_n && acc && !redirect_valid)
            tag_q[tag_wr_q] <= fetch_pc_q;
        if (rst_n && rsp_keep) begin
            fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
            fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
        end
    end

    // No bypass: a response becomes visible the cycle after it is written.
    assign out_valid        = rst_n && (fifo_cnt_q != '0);
    assign out_instr        = fifo_instr_q[fifo_rd_q];
    assign out_pc           = fifo_pc_q[fifo_rd_q];
    assign out_pc_plus_four = out_pc + XLEN'(4);

endmodule
